// File: rtl/verificar_senha_pkg.sv
// Shared types and constants for the PIN verifier: packed PIN/setup/BCD records
// and the verifier state encoding.
package verificar_senha_pkg;

    localparam logic [3:0] DIGIT_BLANK = 4'hE;
    localparam logic [3:0] BCD_DASH    = 4'hB;
    localparam logic [3:0] BCD_BLANK   = 4'hF;

    typedef struct packed {
        logic            status;
        logic [3:0][3:0] digit;
    } pinPac_t;

    typedef struct packed {
        logic [14:0] misc;
        pinPac_t     master_pin;
        pinPac_t     pin1;
        pinPac_t     pin2;
        pinPac_t     pin3;
        pinPac_t     pin4;
    } setupPac_t;

    typedef struct packed {
        logic [3:0] bcd5;
        logic [3:0] bcd4;
        logic [3:0] bcd3;
        logic [3:0] bcd2;
        logic [3:0] bcd1;
        logic [3:0] bcd0;
    } bcdPac_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_RESULT,
        ST_LOCKED
    } verif_state_t;

    function automatic logic has_blank(input logic [15:0] d);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (d[4*i +: 4] == DIGIT_BLANK) found = 1'b1;
        end
        return found;
    endfunction

endpackage

// File: rtl/verificar_senha_pin_match.sv
// Combinational compare of one stored PIN slot against the entered digits.
// A blank digit on either side never matches; an inactive slot never matches.
module pin_match
    import verificar_senha_pkg::*;
(
    input  logic [16:0] slot,
    input  logic [15:0] digits,
    output logic        match
);

    pinPac_t slot_s;

    assign slot_s = slot;
    assign match  = slot_s.status
                 && (slot_s.digit == digits)
                 && !has_blank(digits)
                 && !has_blank(slot_s.digit);

endmodule

// File: rtl/verificar_senha.sv
// PIN verifier: compares a completed entry against master/user PINs, pulses
// grant/deny, and enforces a timed lockout. Optional BCD lockout display: VERIF_LOCK_BCD_EN.
//
// state     | meaning
// ST_IDLE   | waiting for a rising edge of pin_in status
// ST_CHECK  | comparing registered entry against registered setup slots
// ST_RESULT | one-cycle grant/deny pulse, fail counter update
// ST_LOCKED | lockout countdown, entries are rejected
module verificar_senha
    import verificar_senha_pkg::*;
#(
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_S      = 30,
    parameter int TICKS_PER_S = 50_000_000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] pin_in,
    input  logic [99:0] setup_in,
    output logic        pin_ok,
    output logic        pin_master,
    output logic        pin_fail,
    output logic        pin_rejected,
    output logic        locked,
    output logic [2:0]  fail_count,
    output logic [6:0]  lock_remain
`ifdef VERIF_LOCK_BCD_EN
    ,
    output logic [23:0] bcd_out
`endif
);

    localparam int              PRESC_W   = (TICKS_PER_S > 1) ? $clog2(TICKS_PER_S) : 1;
    localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(TICKS_PER_S - 1);
    localparam logic [2:0]      MAX_FC    = 3'(MAX_TRIES);
    localparam logic [6:0]      LOCK_INIT = 7'(LOCK_S);

    pinPac_t      pin_s;
    setupPac_t    setup_s;
    verif_state_t state, state_nxt;

    logic               status_q;
    logic               status_edge;
    logic [15:0]        digits_q;
    logic [4:0][16:0]   slot_q;
    logic [4:0]         slot_hit;
    logic               hit_master_q;
    logic               hit_user_q;
    logic               rej_q;
    logic [2:0]         fail_nxt;
    logic [PRESC_W-1:0] presc;
    logic               unused_setup_misc;

    assign pin_s             = pin_in;
    assign setup_s           = setup_in;
    assign status_edge       = pin_s.status & ~status_q;
    assign pin_rejected      = rej_q;
    assign unused_setup_misc = ^setup_s.misc;

    // slot 0 is the master PIN, slots 1..4 are the user PINs
    for (genvar g = 0; g < 5; g++) begin : g_match
        pin_match u_pin_match (
            .slot   (slot_q[g]),
            .digits (digits_q),
            .match  (slot_hit[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        pin_ok     = 1'b0;
        pin_master = 1'b0;
        pin_fail   = 1'b0;
        fail_nxt   = fail_count;
        case (state)
            ST_IDLE: begin
                if (status_edge) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                state_nxt = ST_RESULT;
            end
            ST_RESULT: begin
                if (hit_master_q || hit_user_q) begin
                    pin_ok     = 1'b1;
                    pin_master = hit_master_q;
                    fail_nxt   = 3'd0;
                    state_nxt  = ST_IDLE;
                end else begin
                    pin_fail = 1'b1;
                    if (fail_count < MAX_FC) fail_nxt = fail_count + 3'd1;
                    state_nxt = (fail_nxt == MAX_FC) ? ST_LOCKED : ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (presc == PRESC_TC && lock_remain == 7'd1) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q     <= 1'b0;
            digits_q     <= '0;
            slot_q       <= '0;
            hit_master_q <= 1'b0;
            hit_user_q   <= 1'b0;
            rej_q        <= 1'b0;
            fail_count   <= 3'd0;
            locked       <= 1'b0;
            lock_remain  <= 7'd0;
            presc        <= '0;
        end else begin
            status_q <= pin_s.status;
            rej_q    <= (state == ST_LOCKED) && status_edge;

            if (state == ST_IDLE && status_edge) begin
                digits_q  <= pin_s.digit;
                slot_q[0] <= setup_s.master_pin;
                slot_q[1] <= setup_s.pin1;
                slot_q[2] <= setup_s.pin2;
                slot_q[3] <= setup_s.pin3;
                slot_q[4] <= setup_s.pin4;
            end

            if (state == ST_CHECK) begin
                hit_master_q <= slot_hit[0];
                hit_user_q   <= |slot_hit[4:1];
            end

            if (state == ST_RESULT) fail_count <= fail_nxt;

            if (state == ST_RESULT && state_nxt == ST_LOCKED) begin
                locked      <= 1'b1;
                lock_remain <= LOCK_INIT;
                presc       <= '0;
            end else if (state == ST_LOCKED) begin
                if (presc == PRESC_TC) begin
                    presc       <= '0;
                    lock_remain <= lock_remain - 7'd1;
                    if (lock_remain == 7'd1) locked <= 1'b0;
                end else begin
                    presc <= presc + PRESC_W'(1);
                end
            end
        end
    end

`ifdef VERIF_LOCK_BCD_EN
    bcdPac_t bcd_s;

    always_comb begin
        bcd_s = {6{BCD_BLANK}};
        if (locked) begin
            bcd_s.bcd5 = BCD_DASH;
            bcd_s.bcd4 = BCD_DASH;
            bcd_s.bcd3 = BCD_DASH;
            bcd_s.bcd2 = BCD_DASH;
            bcd_s.bcd1 = 4'(lock_remain / 7'd10);
            bcd_s.bcd0 = 4'(lock_remain % 7'd10);
        end
    end

    assign bcd_out = bcd_s;
`endif

endmodule

// File: tb/tb_verificar_senha.sv
// Directed bench for verificar_senha with a short lockout (4 ticks/s, 3 s).
module tb_verificar_senha;
    import verificar_senha_pkg::*;

    localparam int TPS = 4;
    localparam int LS  = 3;
    localparam int MT  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] pin_in;
    logic [99:0] setup_in;
    logic        pin_ok, pin_master, pin_fail, pin_rejected, locked;
    logic [2:0]  fail_count;
    logic [6:0]  lock_remain;
`ifdef VERIF_LOCK_BCD_EN
    logic [23:0] bcd_out;
`endif

    pinPac_t   pin_v;
    setupPac_t setup_v;

    assign pin_in   = pin_v;
    assign setup_in = setup_v;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    verificar_senha #(
        .MAX_TRIES   (MT),
        .LOCK_S      (LS),
        .TICKS_PER_S (TPS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pin_in       (pin_in),
        .setup_in     (setup_in),
        .pin_ok       (pin_ok),
        .pin_master   (pin_master),
        .pin_fail     (pin_fail),
        .pin_rejected (pin_rejected),
        .locked       (locked),
        .fail_count   (fail_count),
        .lock_remain  (lock_remain)
`ifdef VERIF_LOCK_BCD_EN
        ,
        .bcd_out      (bcd_out)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // status rises in cycle N, held 2 cycles; result expected in cycle N+2
    task automatic entry(input string tag, input logic [15:0] d, input logic exp_ok,
                         input logic exp_master, input logic [2:0] exp_fc,
                         input logic exp_lock, input logic glitch_setup);
        setupPac_t saved;
        @(negedge clk);
        pin_v.digit  = d;
        pin_v.status = 1'b1;
        @(negedge clk);
        check({tag, " early pulse"}, {pin_ok, pin_fail}, 2'b00);
        saved = setup_v;
        if (glitch_setup) setup_v = '0;
        @(negedge clk);
        check({tag, " pin_ok"},     pin_ok,     exp_ok);
        check({tag, " pin_master"}, pin_master, exp_master);
        check({tag, " pin_fail"},   pin_fail,   !exp_ok);
        pin_v.status = 1'b0;
        setup_v      = saved;
        @(negedge clk);
        check({tag, " single pulse"}, {pin_ok, pin_fail, pin_master}, 3'b000);
        check({tag, " fail_count"}, fail_count, exp_fc);
        check({tag, " locked"},     locked,     exp_lock);
    endtask

    // entered at the cycle right after the locking pin_fail pulse
    task automatic countdown(input string tag, input logic inject);
        logic [6:0] exp_r;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) @(negedge clk);
            exp_r = (k < 4) ? 7'd3 : (k < 8) ? 7'd2 : (k < 12) ? 7'd1 : 7'd0;
            check($sformatf("%s remain k=%0d", tag, k), lock_remain, exp_r);
            check($sformatf("%s locked k=%0d", tag, k), locked, exp_r != 0);
            check($sformatf("%s rejected k=%0d", tag, k), pin_rejected, inject && k == 6);
            check($sformatf("%s no result k=%0d", tag, k), {pin_ok, pin_fail}, 2'b00);
`ifdef VERIF_LOCK_BCD_EN
            check($sformatf("%s bcd k=%0d", tag, k), bcd_out,
                  (exp_r != 0) ? {16'hBBBB, 4'h0, exp_r[3:0]} : 24'hFFFFFF);
`endif
            if (inject && k == 5) begin
                pin_v.digit  = 16'h1234;
                pin_v.status = 1'b1;
            end
            if (k == 7) pin_v.status = 1'b0;
        end
    endtask

    initial begin
        rst     = 1'b0;
        pin_v   = '0;
        setup_v = '0;
        #2;
        check("reset locked",      locked,      1'b0);
        check("reset fail_count",  fail_count,  3'd0);
        check("reset lock_remain", lock_remain, 7'd0);
        check("reset pulses", {pin_ok, pin_master, pin_fail, pin_rejected}, 4'b0000);
        @(negedge clk);
        rst = 1'b1;

        setup_v.pin1 = '{status: 1'b1, digit: 16'h1234};
        entry("user1", 16'h1234, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

        setup_v.master_pin = '{status: 1'b1, digit: 16'h9999};
        setup_v.pin2       = '{status: 1'b1, digit: 16'h9999};
        entry("master", 16'h9999, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);

        setup_v.pin3 = '{status: 1'b0, digit: 16'h5555};
        entry("inactive", 16'h5555, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);

        setup_v.pin4 = '{status: 1'b1, digit: 16'h1E34};
        entry("blank", 16'h1E34, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);

        entry("setup glitch", 16'h1234, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);

        entry("wrong1", 16'h0000, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
        entry("wrong2", 16'h5555, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
        entry("wrong3", 16'h4321, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0);
        countdown("lock1", 1'b1);
        check("after expiry fail_count", fail_count, 3'd3);

        entry("relock", 16'h0000, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0);
        countdown("lock2", 1'b0);
        entry("clear", 16'h1234, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

        entry("wrong4", 16'h0000, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
        entry("wrong5", 16'h0000, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
        entry("wrong6", 16'h0000, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("pre-reset remain", lock_remain, 7'd2);
        #1 rst = 1'b0;
        #1;
        check("mid-lock reset locked",     locked,      1'b0);
        check("mid-lock reset fail_count", fail_count,  3'd0);
        check("mid-lock reset remain",     lock_remain, 7'd0);
`ifdef VERIF_LOCK_BCD_EN
        check("mid-lock reset bcd", bcd_out, 24'hFFFFFF);
`endif
        @(negedge clk);
        rst = 1'b1;
        entry("after reset", 16'h9999, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/verificar_senha.md
Name: verificar_senha

Overview:
Downstream stage of the PIN assembler. It consumes the packed PIN (pinPac_t), checks it against the master PIN and user PINs 1-4 in setupPac_t, and emits one-cycle grant or deny pulses. After repeated failures it enforces a timed lockout. The outputs feed the operational lock controller.

Parameters:
MAX_TRIES, 3, consecutive failures that trigger lockout (range 1..7)
LOCK_S, 30, lockout duration in seconds (range 1..99)
TICKS_PER_S, 50_000_000, clk cycles per second

Ports:
clk  in  1  system clock; the only clock
rst  in  1  asynchronous reset, active-low (asserted when 0)
pin_in  in  17  pinPac_t from the PIN assembler; status high marks a completed entry
setup_in  in  100  setupPac_t; master_pin and pin1..pin4 are used, each with its own status
pin_ok  out  1  one-cycle pulse: PIN accepted
pin_master  out  1  one-cycle pulse: accepted PIN is the master PIN
pin_fail  out  1  one-cycle pulse: PIN rejected
pin_rejected  out  1  one-cycle pulse: entry ignored because lockout is active
locked  out  1  high while lockout is active
fail_count  out  3  consecutive failures, saturating at MAX_TRIES
lock_remain  out  7  seconds of lockout remaining; 0 when not locked

Behaviour:
- Reset (rst=0, async): state IDLE. All pulse outputs 0, locked=0, fail_count=0, lock_remain=0. Second prescaler and status-edge register cleared.
- Attempt detection: rising edge of pin_in.status only. The assembler holds status high for 2 cycles; this yields exactly one attempt.
- States:
  - IDLE: on a status edge, register pin_in digits and the setup PIN fields, then go to CHECK.
  - CHECK: compare the registered values (changes to setup_in during the check are ignored), then go to RESULT.
  - RESULT: drive pulses for one cycle, update fail_count, then go to IDLE, or to LOCKED if the lockout condition is met.
  - LOCKED: counts down.
- Latency: status edge sampled at cycle N. Pulse outputs are high during cycle N+2.
- Match rule: a slot matches only if slot.status=1, all four digits are equal, and no digit equals 4'hE (blank). A pin_in containing any 4'hE digit always fails.
- Priority: master is checked first. A master match gives pin_ok=1 and pin_master=1. A pin1..pin4 match gives pin_ok=1 only. No match gives pin_fail=1.
- pin_ok and pin_fail are never high together.
- Success clears fail_count to 0.
- Failure increments fail_count, saturating at MAX_TRIES. If the result is fail_count==MAX_TRIES, go to LOCKED in the cycle after the pin_fail pulse.
- On LOCKED entry: locked=1, lock_remain=LOCK_S, prescaler=0.
- Countdown: each time the prescaler reaches TICKS_PER_S-1 it wraps and lock_remain decrements.
- Lockout exit: when lock_remain goes 1 to 0, locked=0 on that same edge and the state returns to IDLE. fail_count stays at MAX_TRIES, so the next single failure re-locks and the next success clears it.
- Status edge while LOCKED: pin_rejected pulses during the next cycle. No compare is done and the countdown is unaffected.
- Status edge in CHECK or RESULT: dropped, no pulse. The assembler guarantees at least 3 cycles between entries.
- Reset asserted mid-lockout or mid-check: immediate return to the reset values. The lockout does not persist across reset.

Optional Feature:
Macro VERIF_LOCK_BCD_EN.
- Defined: adds output port bcd_out (24 bits, bcdPac_t).
- While locked:
  - BCD1 = tens of lock_remain, BCD0 = units.
  - BCD2..BCD5 = 4'hB (dash glyph).
  - The value updates in the same cycle as lock_remain.
- When not locked: all six fields = 4'hF (blank).
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package: pinPac_t, setupPac_t, bcdPac_t, constants DIGIT_BLANK=4'hE and BCD_DASH=4'hB, and the verifier state enum.
- One sub-module, pin_match: combinational compare of one pinPac_t slot against the entered digits, including the blank and status rules. It is instantiated 5 times.
- The countdown and prescaler stay inline.

Test Plan:
- setup pin1=1234 (status=1), entry 1-2-3-4 → pin_ok=1 for one cycle at N+2, pin_master=0, fail_count=0.
- master=9999 and pin2=9999 both active, entry 9999 → pin_ok=1 and pin_master=1.
- pin3=5555 with status=0, entry 5555 → pin_fail=1, fail_count=1.
- Three wrong entries with TICKS_PER_S=4 and LOCK_S=3 → third pin_fail, then locked=1 and lock_remain 3→2→1→0 at 4-cycle steps. A mid-lockout entry gives pin_rejected=1. After expiry, one wrong entry re-locks; one correct entry gives pin_ok and fail_count=0.
- Status held high 2 cycles → exactly one result pulse.
- rst=0 during lockout with lock_remain=2 → locked=0, fail_count=0, lock_remain=0 immediately. With VERIF_LOCK_BCD_EN defined, bcd_out shows all fields 4'hF.
